shift_add_multiplier: RTL and testbench
=======================================

Name: shift_add_multiplier

Overview:
- Sequential unsigned shift-and-add multiplier with two four-phase handshakes.
- Input side: valid_data/ret_ack. Output side: Done_Flag/ack.
- Instances chain back-to-back: one stage's Done_Flag/ack pair drives the next stage's valid_data/ret_ack pair.
- One multiplier bit is processed per clock; the full product is registered.

Parameters:
- WIDTH, 32, operand width in bits. Product width is 2*WIDTH.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-low reset (0 = reset asserted).
- a, input, WIDTH, multiplicand (unsigned).
- b, input, WIDTH, multiplier (unsigned).
- valid_data, input, 1, upstream asserts when a/b are stable; held until ret_ack is seen.
- ret_ack, output, 1, operands captured; held high until valid_data drops.
- producto, output, 2*WIDTH, registered product.
- Done_Flag, output, 1, producto valid; held until ack.
- ack, input, 1, downstream consumed producto.

Behaviour:
- Reset (reset=0, async): state=IDLE; producto=0, Done_Flag=0, ret_ack=0; internal accumulator, shift registers and counter cleared. Reset mid-operation aborts immediately and discards the partial result.
- States: IDLE, BUSY, DONE, WAIT_ACK_LOW.
- IDLE: on a clock edge with valid_data=1 and ret_ack=0:
  - capture a into the multiplicand register (zero-extended to 2*WIDTH) and b into the multiplier register;
  - clear accumulator and counter; set ret_ack=1; go to BUSY.
  - valid_data=1 while ret_ack=1 is ignored (no re-capture of the same operands).
- ret_ack clears on the first edge where valid_data=0. It is independent of state, so it may clear during BUSY.
- BUSY, each cycle:
  - if multiplier LSB=1, accumulator += multiplicand;
  - multiplicand <<= 1, multiplier >>= 1, counter++.
  - After WIDTH cycles: producto <= accumulator, Done_Flag=1, go to DONE.
  - Latency: Done_Flag rises WIDTH+1 rising edges after the capture edge (33 for WIDTH=32).
- Arithmetic: unsigned; accumulator is 2*WIDTH bits; no overflow possible. Max case: (2^WIDTH-1)^2.
- DONE: Done_Flag and producto hold. When ack=1 is sampled: Done_Flag=0, go to WAIT_ACK_LOW.
- WAIT_ACK_LOW: when ack=0 is sampled, go to IDLE.
  - A new capture is possible only from IDLE, so it happens no earlier than the edge after ack is seen low.
- producto changes only on entry to DONE. It holds the last result through IDLE/BUSY of the next operation.
- ack asserted outside DONE is ignored.
- Zero operands still take the full latency unless the optional feature is enabled.

Optional Feature:
- Macro: MUL_EARLY_TERM_EN.
- Defined: BUSY exits to DONE as soon as the remaining multiplier register is zero, with a minimum of 1 BUSY cycle. Example: b=0 gives Done_Flag 2 edges after capture. Results are identical.
- Undefined: fixed WIDTH-cycle latency.

Decomposition:
- Package mul_pkg holds:
  - state enum (IDLE, BUSY, DONE, WAIT_ACK_LOW);
  - default WIDTH constant;
  - counter width function clog2(WIDTH+1).
- One sub-module is natural: mul_datapath, containing the accumulator, shift registers, adder and counter, driven by the FSM in the top module.

Test Plan:
- Basic operation (WIDTH=32): a=10, b=10, valid_data held until ret_ack -> ret_ack=1 one edge after valid; producto=100, Done_Flag=1 exactly 33 edges after capture; ack=1 -> Done_Flag=0 next edge.
- Zero operands: a=19347, b=0 -> producto=0 (33-cycle latency; 2 cycles with MUL_EARLY_TERM_EN). Then a=0, b=0 -> producto=0.
- Maximum operands: a=b=32'hFFFFFFFF -> producto=64'hFFFFFFFE00000001.
- Hold rules:
  - valid_data held high after the result -> no second capture until valid_data drops and rises again;
  - ack held high -> no new capture until ack=0.
- Asynchronous reset: reset=0 pulse mid-BUSY, with no clock edge required -> outputs 0 immediately; after release, the next valid_data produces a correct fresh product.
- Chain: stage 1 #(32) computes 10*10, stage 2 #(64) multiplies by c=10 -> final producto=1000; each stage's ret_ack drops its upstream valid.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
// Optional feature macro used elsewhere in this slice: MUL_EARLY_TERM_EN.
package mul_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    BUSY         = 2'd1,
    DONE         = 2'd2,
    WAIT_ACK_LOW = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH = 32;

  // Bits needed for a step counter that must reach WIDTH itself
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Operand/result handshake bundle for one multiplier stage.
// slave = the multiplier's view, master = the producer/consumer's view.
interface shift_add_multiplier_if
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               valid_data;
  logic               ret_ack;
  logic [2*WIDTH-1:0] producto;
  logic               Done_Flag;
  logic               ack;

  modport master (
    output a, b, valid_data, ack,
    input  ret_ack, producto, Done_Flag
  );

  modport slave (
    input  a, b, valid_data, ack,
    output ret_ack, producto, Done_Flag
  );

endinterface

// File: rtl/mul_datapath.sv
// Accumulator, shifting operand registers, adder and step counter.
// With MUL_EARLY_TERM_EN defined, 'finished' also fires once the remaining
// multiplier bits are all zero (after at least one step).
module mul_datapath
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc,
  output logic               finished
);

  localparam int CNT_W = cnt_width(WIDTH);

  logic [2*WIDTH-1:0] mcand_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] sum_s;
  logic [WIDTH-1:0]   mplier_r;
  logic [CNT_W-1:0]   cnt_r;

  // Conditional add of the shifted multiplicand for the current multiplier bit
  always_comb begin
    sum_s = acc_r;
    if (mplier_r[0]) begin
      sum_s = acc_r + mcand_r;
    end else begin
      sum_s = acc_r;
    end
  end

  // Operand capture on load, one multiplier bit consumed per step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand_r  <= '0;
      mplier_r <= '0;
      acc_r    <= '0;
      cnt_r    <= '0;
    end else if (load) begin
      mcand_r  <= {{WIDTH{1'b0}}, a};
      mplier_r <= b;
      acc_r    <= '0;
      cnt_r    <= '0;
    end else if (step) begin
      acc_r    <= sum_s;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      cnt_r    <= cnt_r + CNT_W'(1);
    end else begin
      acc_r    <= acc_r;
    end
  end

`ifdef MUL_EARLY_TERM_EN
  // Remaining multiplier bits all zero means the accumulator is already final
  assign finished = (cnt_r == CNT_W'(WIDTH)) ||
                    ((cnt_r != CNT_W'(0)) && (mplier_r == '0));
`else
  assign finished = (cnt_r == CNT_W'(WIDTH));
`endif

  assign acc = acc_r;

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier with four-phase handshakes
// on both sides (valid_data/ret_ack in, Done_Flag/ack out).
// Optional: define MUL_EARLY_TERM_EN to leave BUSY once the multiplier runs out of ones.
module shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                   clk,
  input logic                   reset,
  shift_add_multiplier_if.slave bus
);

  state_t             state_r;
  logic               ret_ack_r;
  logic               done_r;
  logic [2*WIDTH-1:0] producto_r;
  logic [2*WIDTH-1:0] acc_s;
  logic               load_s;
  logic               step_s;
  logic               finished_s;

  // Datapath strobes decoded from the controller state
  always_comb begin
    load_s = 1'b0;
    step_s = 1'b0;
    case (state_r)
      IDLE:    load_s = bus.valid_data && !ret_ack_r;
      BUSY:    step_s = !finished_s;
      default: begin
        load_s = 1'b0;
        step_s = 1'b0;
      end
    endcase
  end

  mul_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk      (clk),
    .reset    (reset),
    .load     (load_s),
    .step     (step_s),
    .a        (bus.a),
    .b        (bus.b),
    .acc      (acc_s),
    .finished (finished_s)
  );

  // Controller FSM with registered handshake outputs and product
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      ret_ack_r  <= 1'b0;
      done_r     <= 1'b0;
      producto_r <= '0;
    end else begin
      // ret_ack follows the upstream request regardless of state
      if (!bus.valid_data) begin
        ret_ack_r <= 1'b0;
      end else if (load_s) begin
        ret_ack_r <= 1'b1;
      end else begin
        ret_ack_r <= ret_ack_r;
      end

      case (state_r)
        IDLE: begin
          if (load_s) begin
            state_r <= BUSY;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (finished_s) begin
            producto_r <= acc_s;
            done_r     <= 1'b1;
            state_r    <= DONE;
          end else begin
            state_r    <= BUSY;
          end
        end
        DONE: begin
          if (bus.ack) begin
            done_r  <= 1'b0;
            state_r <= WAIT_ACK_LOW;
          end else begin
            state_r <= DONE;
          end
        end
        WAIT_ACK_LOW: begin
          if (!bus.ack) begin
            state_r <= IDLE;
          end else begin
            state_r <= WAIT_ACK_LOW;
          end
        end
        default: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ret_ack   = ret_ack_r;
  assign bus.Done_Flag = done_r;
  assign bus.producto  = producto_r;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: drivers push expected products,
// monitors pop and compare on each Done_Flag rising edge.
module tb_shift_add_multiplier;
  import mul_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shift_add_multiplier_if #(.WIDTH(W))   m_if ();
  shift_add_multiplier_if #(.WIDTH(W))   s1_if ();
  shift_add_multiplier_if #(.WIDTH(2*W)) s2_if ();

  shift_add_multiplier #(.WIDTH(W))   dut    (.clk(clk), .reset(reset), .bus(m_if.slave));
  shift_add_multiplier #(.WIDTH(W))   stage1 (.clk(clk), .reset(reset), .bus(s1_if.slave));
  shift_add_multiplier #(.WIDTH(2*W)) stage2 (.clk(clk), .reset(reset), .bus(s2_if.slave));

  assign s2_if.a          = s1_if.producto;
  assign s2_if.valid_data = s1_if.Done_Flag;
  assign s1_if.ack        = s2_if.ret_ack;

  int errors = 0;
  int checks = 0;
  logic [63:0]  exp_q[$];
  logic [127:0] chain_q[$];
  logic main_prev;
  logic chain_prev;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected edges from capture to Done_Flag for multiplier value bv
  function automatic int exp_lat(input logic [W-1:0] bv);
    int hb;
    int lat;
    hb = 1;
    for (int i = 0; i < W; i++) if (bv[i]) hb = i + 1;
`ifdef MUL_EARLY_TERM_EN
    lat = hb + 1;
`else
    lat = (hb > W) ? hb + 1 : W + 1;
`endif
    return lat;
  endfunction

  // Main monitor: compare product at every Done_Flag rise
  initial begin
    main_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (m_if.Done_Flag && !main_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got producto %0h expected no result", m_if.producto);
        end else begin
          check("product", {64'd0, m_if.producto}, {64'd0, exp_q.pop_front()});
        end
      end
      main_prev = m_if.Done_Flag;
    end
  end

  // Chain monitor: compare final stage product
  initial begin
    chain_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (s2_if.Done_Flag && !chain_prev) begin
        if (chain_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL chain_unexpected_done: got %0h expected no result", s2_if.producto);
        end else begin
          check("chain_product", s2_if.producto, chain_q.pop_front());
        end
      end
      chain_prev = s2_if.Done_Flag;
    end
  end

  // Present operands; returns at the negedge just after the capture edge
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input bit hold);
    @(negedge clk);
    m_if.a = ia;
    m_if.b = ib;
    m_if.valid_data = 1'b1;
    @(negedge clk);
    check("ret_ack_rise", {127'd0, m_if.ret_ack}, 128'd1);
    if (!hold) m_if.valid_data = 1'b0;
  endtask

  // Count negedges until Done_Flag is seen; -1 on timeout
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (m_if.Done_Flag) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_ack();
    m_if.ack = 1'b1;
    @(negedge clk);
    check("done_drop", {127'd0, m_if.Done_Flag}, 128'd0);
    m_if.ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib);
    int n;
    exp_q.push_back({32'd0, ia} * {32'd0, ib});
    issue(ia, ib, 1'b0);
    wait_done(n);
    check("latency", 128'(n), 128'(exp_lat(ib)));
    do_ack();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b0;
    m_if.a = '0; m_if.b = '0; m_if.valid_data = 1'b0; m_if.ack = 1'b0;
    s1_if.a = '0; s1_if.b = '0; s1_if.valid_data = 1'b0;
    s2_if.b = '0; s2_if.ack = 1'b0;
    #12;
    check("rst_done", {127'd0, m_if.Done_Flag}, 128'd0);
    check("rst_ret_ack", {127'd0, m_if.ret_ack}, 128'd0);
    check("rst_producto", {64'd0, m_if.producto}, 128'd0);
    @(negedge clk);
    reset = 1'b1;

    // Basic: 10*10
    exp_q.push_back(64'd100);
    issue(32'd10, 32'd10, 1'b0);
    wait_done(n);
    check("basic_latency", 128'(n), 128'(exp_lat(32'd10)));
    check("basic_ret_ack_low", {127'd0, m_if.ret_ack}, 128'd0);
    do_ack();

    run_op(32'd19347, 32'd0);
    run_op(32'd0, 32'd0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(32'd1234, 32'd5678);

    // valid_data held high: only one capture
    exp_q.push_back(64'd156);
    issue(32'd12, 32'd13, 1'b1);
    wait_done(n);
    check("hold_latency", 128'(n), 128'(exp_lat(32'd13)));
    do_ack();
    repeat (40) @(negedge clk);
    check("hold_ret_ack", {127'd0, m_if.ret_ack}, 128'd1);
    check("hold_producto", {64'd0, m_if.producto}, 128'd156);
    m_if.valid_data = 1'b0;
    @(negedge clk);
    check("hold_ret_ack_drop", {127'd0, m_if.ret_ack}, 128'd0);
    run_op(32'd7, 32'd6);

    // ack held high blocks a new capture
    exp_q.push_back(64'd45);
    issue(32'd5, 32'd9, 1'b0);
    wait_done(n);
    m_if.ack = 1'b1;
    m_if.a = 32'd3; m_if.b = 32'd3; m_if.valid_data = 1'b1;
    repeat (20) @(negedge clk);
    check("ackhold_no_capture", {127'd0, m_if.ret_ack}, 128'd0);
    check("ackhold_done_low", {127'd0, m_if.Done_Flag}, 128'd0);
    exp_q.push_back(64'd9);
    m_if.ack = 1'b0;
    @(negedge clk);
    check("ackhold_idle_edge", {127'd0, m_if.ret_ack}, 128'd0);
    @(negedge clk);
    check("ackhold_capture", {127'd0, m_if.ret_ack}, 128'd1);
    m_if.valid_data = 1'b0;
    wait_done(n);
    check("ackhold_latency", 128'(n), 128'(exp_lat(32'd3)));
    do_ack();

    // Asynchronous reset mid-BUSY, checked between clock edges
    issue(32'd100, 32'd100, 1'b0);
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_producto", {64'd0, m_if.producto}, 128'd0);
    check("async_done", {127'd0, m_if.Done_Flag}, 128'd0);
    check("async_ret_ack", {127'd0, m_if.ret_ack}, 128'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op(32'd11, 32'd11);

    // Two-stage chain: (10*10)*10
    chain_q.push_back(128'd1000);
    s2_if.b = 64'd10;
    @(negedge clk);
    s1_if.a = 32'd10; s1_if.b = 32'd10; s1_if.valid_data = 1'b1;
    n = -1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (s1_if.ret_ack) begin n = i; break; end
    end
    check("chain_s1_ret_ack", 128'(n), 128'd1);
    s1_if.valid_data = 1'b0;
    n = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (s2_if.Done_Flag) begin n = i; break; end
    end
    check("chain_timeout", {127'd0, (n > 0)}, 128'd1);
    check("chain_s1_released", {127'd0, s1_if.Done_Flag}, 128'd0);
    check("chain_s2_ret_ack_low", {127'd0, s2_if.ret_ack}, 128'd0);
    s2_if.ack = 1'b1;
    @(negedge clk);
    check("chain_done_drop", {127'd0, s2_if.Done_Flag}, 128'd0);
    s2_if.ack = 1'b0;

    repeat (5) @(negedge clk);
    check("main_queue_empty", 128'(exp_q.size()), 128'd0);
    check("chain_queue_empty", 128'(chain_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
